// File: rtl/impl_top_pkg.sv
// Shared types for the UART nibble display.
// Receiver FSM states and frame width.
package impl_top_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchroniser.
// Emits a one-cycle valid pulse per good frame.
module uart_rx
  import impl_top_pkg::*;
#(
  parameter int BIT_RATE = 9600,
  parameter int CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [2:0]    LAST     = 3'(DATA_BITS - 1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          s1;
  logic          s2;
  logic          prev;

  assign data = sh;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      valid <= 1'b0;
    end else begin
      s1    <= rxd;
      s2    <= s1;
      prev  <= s2;
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          // edge, not level: a held-low line cannot restart
          if (en && prev && !s2)
            state <= START;
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            state <= s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            sh  <= {s2, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == LAST)
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            valid <= s2;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/impl_top.sv
// UART byte history shown on LEDs and RGB triples.
// Byte 0x00 clears the whole history.
module impl_top
  import impl_top_pkg::*;
#(
  parameter int BIT_RATE = 9600,
  parameter int CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic [3:0] sw,
  input  logic       uart_rxd,
  output logic [3:0] led,
  output logic [2:0] rgb0,
  output logic [2:0] rgb1,
  output logic [2:0] rgb2,
  output logic [2:0] rgb3
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] stored;
  logic       unused_sw;

  assign unused_sw = sw[3];

  uart_rx #(
    .BIT_RATE(BIT_RATE),
    .CLK_HZ  (CLK_HZ)
  ) u_rx (
    .clk   (clk),
    .resetn(sw[0]),
    .en    (sw[1]),
    .rxd   (uart_rxd),
    .data  (rx_data),
    .valid (rx_valid)
  );

  always_ff @(posedge clk) begin
    if (!sw[0]) begin
      stored <= '0;
      rgb0   <= '0;
      rgb1   <= '0;
      rgb2   <= '0;
      rgb3   <= '0;
    end else if (rx_valid) begin
      if (rx_data == 8'h00) begin
        stored <= '0;
        rgb0   <= '0;
        rgb1   <= '0;
        rgb2   <= '0;
        rgb3   <= '0;
      end else begin
        stored <= rx_data;
        rgb0   <= rx_data[2:0];
        rgb1   <= rgb0;
        rgb2   <= rgb1;
        rgb3   <= rgb2;
      end
    end
  end

  assign led = sw[2] ? stored[7:4] : stored[3:0];

endmodule

// File: tb/tb_impl_top.sv
// Directed bench for impl_top at 16 clocks per bit.
// Expected history values are hand-computed.
module tb_impl_top;

  localparam int CPB = 16;

  logic       clk;
  logic [3:0] sw;
  logic       uart_rxd;
  logic [3:0] led;
  logic [2:0] rgb0;
  logic [2:0] rgb1;
  logic [2:0] rgb2;
  logic [2:0] rgb3;

  int n_chk;
  int n_pass;

  impl_top #(
    .BIT_RATE(9600),
    .CLK_HZ  (9600 * CPB)
  ) dut (
    .clk     (clk),
    .sw      (sw),
    .uart_rxd(uart_rxd),
    .led     (led),
    .rgb0    (rgb0),
    .rgb1    (rgb1),
    .rgb2    (rgb2),
    .rgb3    (rgb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic chk_out(
    input string      tag,
    input logic [3:0] e_led,
    input logic [11:0] e_rgb
  );
    chk({tag, "_led"}, 32'(led), 32'(e_led));
    chk({tag, "_rgb"}, 32'({rgb3, rgb2, rgb1, rgb0}),
        32'(e_rgb));
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop_bit);
    uart_rxd = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_clk(CPB);
    end
    uart_rxd = stop_bit;
    wait_clk(CPB);
    uart_rxd = 1'b1;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    uart_rxd = 1'b1;
    sw       = 4'b0010;
    wait_clk(5);
    chk_out("reset", 4'h0, 12'o0000);
    sw[0] = 1'b1;
    wait_clk(CPB);

    send(8'h41, 1'b1);
    wait_clk(4);
    chk_out("byte_A", 4'h1, 12'o0001);

    // back-to-back frames, no idle gap
    send(8'h31, 1'b1);
    send(8'h42, 1'b1);
    send(8'h32, 1'b1);
    send(8'h43, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    send(8'h34, 1'b1);
    wait_clk(4);
    chk_out("seq8", 4'h4, 12'o3344);
    sw[2] = 1'b1;
    #1 chk("seq8_hi", 32'(led), 32'h3);
    sw[2] = 1'b0;

    send(8'h00, 1'b1);
    wait_clk(4);
    chk_out("zero", 4'h0, 12'o0000);

    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    send(8'h63, 1'b1);
    send(8'h64, 1'b1);
    wait_clk(4);
    chk_out("abcd", 4'h4, 12'o1234);
    sw[2] = 1'b1;
    #1 chk("abcd_hi", 32'(led), 32'h6);
    sw[2] = 1'b0;

    send(8'h55, 1'b0);
    wait_clk(CPB);
    chk_out("frame_err", 4'h4, 12'o1234);
    send(8'h41, 1'b1);
    wait_clk(4);
    chk_out("after_ferr", 4'h1, 12'o2341);

    uart_rxd = 1'b0;
    wait_clk(CPB / 4);
    uart_rxd = 1'b1;
    wait_clk(3 * CPB);
    chk_out("glitch", 4'h1, 12'o2341);

    sw[1] = 1'b0;
    send(8'h42, 1'b1);
    wait_clk(4);
    chk_out("rx_off", 4'h1, 12'o2341);

    sw[1] = 1'b1;
    fork
      send(8'h43, 1'b1);
      begin
        wait_clk(CPB + CPB / 2);
        sw[1] = 1'b0;
      end
    join
    wait_clk(4);
    chk_out("en_drop", 4'h3, 12'o3413);
    sw[1] = 1'b1;

    uart_rxd = 1'b0;
    wait_clk(30 * CPB);
    uart_rxd = 1'b1;
    wait_clk(2 * CPB);
    chk_out("break", 4'h3, 12'o3413);
    send(8'h44, 1'b1);
    wait_clk(4);
    chk_out("after_brk", 4'h4, 12'o4134);

    // reset lands in a high bit of 0xF0
    fork
      send(8'hF0, 1'b1);
      begin
        wait_clk(6 * CPB + CPB / 2);
        sw[0] = 1'b0;
        wait_clk(3);
        chk_out("mid_rst", 4'h0, 12'o0000);
        sw[0] = 1'b1;
      end
    join
    wait_clk(2 * CPB);
    chk_out("post_rst", 4'h0, 12'o0000);
    send(8'h41, 1'b1);
    wait_clk(4);
    chk_out("rst_A", 4'h1, 12'o0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/impl_top.md
IMPL_TOP -- requirements
Module: impl_top

Interface
REQ-001 The block SHALL have parameter BIT_RATE, default 9600, meaning the UART line bit rate in bits/s.
REQ-002 The block SHALL have parameter CLK_HZ, default 50000000, meaning the clk frequency in Hz.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port sw, input, 4 bits: sw[0] is the reset, synchronous and active-low; sw[1] is receive enable; sw[2] is nibble select; sw[3] is unused.
REQ-005 The block SHALL have port uart_rxd, input, 1 bit: the asynchronous UART receive pin, which idles high.
REQ-006 The block SHALL have port led, output, 4 bits: a nibble of the last received byte.
REQ-007 The block SHALL have ports rgb0, rgb1, rgb2 and rgb3, output, 3 bits each: bits[2:0] of the 4 most recent bytes, where rgb0 is the newest.

Function
REQ-008 uart_rxd SHALL pass through a 2-flop synchroniser before any use.
REQ-009 Bit period SHALL be CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division), which is 5208 at the defaults.
REQ-010 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START on a synchronised falling edge while sw[1]=1.
- START: after CYCLES_PER_BIT/2 cycles, sample the line; if 0 go to DATA, if 1 (glitch) return to IDLE.
- DATA: sample every CYCLES_PER_BIT cycles, 8 bits, LSB first.
- STOP: sample after CYCLES_PER_BIT; if 1, emit the byte; if 0 (framing error), discard it; then go to IDLE.
REQ-011 A valid byte SHALL produce a 1-cycle internal rx_valid pulse, and the outputs SHALL update on the following clk edge.
REQ-012 On a valid byte B != 0x00, the history SHALL shift: rgb3<=rgb2, rgb2<=rgb1, rgb1<=rgb0, rgb0<=B[2:0]; the stored byte register <= B.
REQ-013 On a valid byte 0x00, all of rgb0..rgb3 and the stored byte register SHALL clear to 0.
REQ-014 led SHALL equal stored[3:0] when sw[2]=0 and stored[7:4] when sw[2]=1, combinationally from sw[2].
REQ-015 While sw[1]=0, new frames SHALL NOT start; a frame already in progress SHALL complete normally.
REQ-016 A new start bit SHALL be accepted immediately after STOP completes; back-to-back frames SHALL NOT be lost.
REQ-017 A line held low (break) SHALL yield at most one framing-error discard, and the FSM SHALL wait in IDLE for the line to return high before a new falling edge can start a frame.

Reset
REQ-018 While sw[0]=0 at a clk edge, the FSM SHALL go to IDLE, counters and the shift register to 0, synchroniser flops to 1, and stored and rgb0..rgb3 to 0, so led=0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame with no partial byte emitted.

Structure
REQ-020 A shared package SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and the constant for the 8 data bits.
REQ-021 Receive logic SHALL be one sub-module uart_rx (parameters BIT_RATE and CLK_HZ; ports clk, resetn, en, rxd, data[7:0], valid); impl_top holds the synchroniser-free display and history logic.

Verification
REQ-022 Reset, then send 'A' (0x41) at 9600 baud -> led=4'h1, rgb0=3'b001, rgb1..rgb3=0.
REQ-023 Send '1', 'B', '2', 'C', '3', 'D', '4' after 'A' -> after '4' (0x34): rgb0=100, rgb1=100 ('D' 0x44), rgb2=011 ('3'), rgb3=011 ('C'); led=4'h4.
REQ-024 Send 0x00 -> all rgb=0 and led=0; then 'a','b','c','d' -> rgb0=100, rgb1=011, rgb2=010, rgb3=001; with sw[2]=1, led=4'h6.
REQ-025 Frame with stop bit=0 -> no output change; a following valid 'A' is still received correctly.
REQ-026 A 1/4-bit low glitch on an idle line -> no byte received; sw[0] pulsed low mid-frame -> outputs 0 and the rest of the frame is ignored.
